// File: rtl/cp0_intc_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_intc_if
// Purpose  : Bus bundle between the M-stage pipeline logic and the CP0
//            interrupt controller (IRQ lines, mtc0/mfc0, eret, redirect).
// Revision : 1.0 - initial release
// ============================================================================
interface cp0_intc_if;
    logic [5:0]  HWINT_I;
    logic [4:0]  SEL_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic [31:0] PC_I;
    logic        VALID_I;
    logic        ERET_I;
    logic        INT_REQ_O;
    logic [31:0] EPC_O;

    // Pipeline side drives requests and instruction context
    modport master (
        output HWINT_I, SEL_I, WE_I, DAT_I, PC_I, VALID_I, ERET_I,
        input  DAT_O, INT_REQ_O, EPC_O
    );

    // Controller side
    modport slave (
        input  HWINT_I, SEL_I, WE_I, DAT_I, PC_I, VALID_I, ERET_I,
        output DAT_O, INT_REQ_O, EPC_O
    );
endinterface
`default_nettype wire

// File: rtl/cp0_intc.sv
`default_nettype none
// ============================================================================
// Module   : cp0_intc
// Purpose  : Coprocessor-0 interrupt controller. Masks/gates level IRQs,
//            raises the M-stage interrupt request, captures EPC, and exposes
//            SR/Cause/EPC/PRId for mfc0/mtc0/eret.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_intc #(
    parameter logic [31:0] PRID = 32'h0000_4D50
) (
    input  wire logic  CLK_I,
    input  wire logic  RST_I,
    cp0_intc_if.slave  bus
);

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic [5:0]  ip_q,  ip_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic [31:0] dat_o;
    logic        unused_pc_lsbs;

    // Raw (unregistered) IRQ lines so the request has zero-cycle latency
    assign int_req = (|(bus.HWINT_I & im_q)) & ie_q & ~exl_q & bus.VALID_I;

    // PC low bits are discarded: EPC is always word aligned
    assign unused_pc_lsbs = ^bus.PC_I[1:0];

    // Next-state: interrupt wins; otherwise eret clears EXL and mtc0 writes
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        ip_d  = bus.HWINT_I;
        epc_d = epc_q;
        if (int_req) begin
            // The interrupted instruction does not commit: drop mtc0/eret
            epc_d = {bus.PC_I[31:2], 2'b00};
            exl_d = 1'b1;
        end else begin
            if (bus.WE_I) begin
                case (bus.SEL_I)
                    SEL_SR: begin
                        im_d  = bus.DAT_I[15:10];
                        exl_d = bus.DAT_I[1];
                        ie_d  = bus.DAT_I[0];
                    end
                    SEL_EPC: epc_d = {bus.DAT_I[31:2], 2'b00};
                    default: ;
                endcase
            end
            // eret overrides the EXL bit of a same-cycle SR write
            if (bus.ERET_I) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            ip_q  <= 6'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    // mfc0 read mux of pre-edge state (no write bypass)
    always_comb begin
        dat_o = 32'd0;
        case (bus.SEL_I)
            SEL_SR:    dat_o = {16'd0, im_q, 8'd0, exl_q, ie_q};
            SEL_CAUSE: dat_o = {16'd0, ip_q, 10'd0};
            SEL_EPC:   dat_o = epc_q;
            SEL_PRID:  dat_o = PRID;
            default:   dat_o = 32'd0;
        endcase
    end

    assign bus.DAT_O     = dat_o;
    assign bus.INT_REQ_O = int_req;
    assign bus.EPC_O     = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_intc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_intc
// Purpose  : Self-checking bench for cp0_intc using an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_intc;

    localparam logic [31:0] C_PRID = 32'h0000_4D50;
    localparam int          P_DAT  = 0;
    localparam int          P_INT  = 1;
    localparam int          P_EPC  = 2;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b0;

    cp0_intc_if bus ();

    cp0_intc #(.PRID(C_PRID)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus.slave)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Pop every queued expectation and compare against the live output
    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            case (e.port)
                P_DAT:   obs = bus.DAT_O;
                P_INT:   obs = {31'd0, bus.INT_REQ_O};
                default: obs = bus.EPC_O;
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    task automatic expect_out(input string tag, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        q_exp.push_back(e);
        #1;
        drain();
    endtask

    task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        bus.SEL_I = sel;
        expect_out(tag, P_DAT, exp);
    endtask

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge CLK_I);
        #2;
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] dat);
        bus.SEL_I = sel;
        bus.DAT_I = dat;
        bus.WE_I  = 1'b1;
        tick();
        bus.WE_I  = 1'b0;
    endtask

    initial begin
        bus.HWINT_I = 6'h3F;
        bus.SEL_I   = 5'd0;
        bus.WE_I    = 1'b0;
        bus.DAT_I   = 32'd0;
        bus.PC_I    = 32'd0;
        bus.VALID_I = 1'b1;
        bus.ERET_I  = 1'b0;
        #1 RST_I = 1'b1;

        // Reset state
        rd("rst_sr",    5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc",   5'd14, 32'd0);
        rd("rst_prid",  5'd15, C_PRID);
        rd("rst_sel7",  5'd7,  32'd0);
        expect_out("rst_int", P_INT, 32'd0);
        expect_out("rst_epco", P_EPC, 32'd0);
        tick();
        RST_I = 1'b0;
        tick();
        rd("cause_all", 5'd13, 32'h0000_FC00);
        expect_out("int_masked_rst", P_INT, 32'd0);

        // Timer request taken
        bus.HWINT_I = 6'h00;
        bus.PC_I    = 32'h0000_3008;
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_wr", 5'd12, 32'h0000_0401);
        expect_out("int_idle", P_INT, 32'd0);
        bus.HWINT_I = 6'h01;
        expect_out("int_same_cycle", P_INT, 32'd1);
        tick();
        expect_out("epc_taken", P_EPC, 32'h0000_3008);
        rd("sr_exl", 5'd12, 32'h0000_0403);
        expect_out("int_blocked_exl", P_INT, 32'd0);
        rd("cause_ip2", 5'd13, 32'h0000_0400);

        // eret with a same-cycle EPC write; request re-asserts after
        bus.PC_I   = 32'h0000_300B;
        bus.ERET_I = 1'b1;
        mtc0(5'd14, 32'h0000_1111);
        bus.ERET_I = 1'b0;
        rd("sr_eret", 5'd12, 32'h0000_0401);
        expect_out("epc_eret_wr", P_EPC, 32'h0000_1110);
        expect_out("int_reassert", P_INT, 32'd1);

        // Interrupt beats a simultaneous mtc0 to EPC
        mtc0(5'd14, 32'hDEAD_BEEF);
        expect_out("epc_collision", P_EPC, 32'h0000_3008);
        rd("sr_collision", 5'd12, 32'h0000_0403);

        // Masking: IM2 cleared, EXL cleared by mtc0
        mtc0(5'd12, 32'h0000_0001);
        expect_out("int_masked", P_INT, 32'd0);
        rd("cause_masked", 5'd13, 32'h0000_0400);
        bus.HWINT_I = 6'h02;
        rd("cause_lag", 5'd13, 32'h0000_0400);
        tick();
        rd("cause_ip3", 5'd13, 32'h0000_0800);

        // Bubble gating
        mtc0(5'd12, 32'h0000_0401);
        bus.HWINT_I = 6'h01;
        bus.VALID_I = 1'b0;
        expect_out("int_bubble", P_INT, 32'd0);
        bus.VALID_I = 1'b1;
        bus.PC_I    = 32'h0000_3010;
        expect_out("int_valid", P_INT, 32'd1);
        tick();
        expect_out("epc_3010", P_EPC, 32'h0000_3010);

        // mtc0 EPC while in handler, then eret + SR write together
        mtc0(5'd14, 32'h0000_4003);
        expect_out("epc_mtc0", P_EPC, 32'h0000_4000);
        bus.ERET_I = 1'b1;
        mtc0(5'd12, 32'h0000_0803);
        bus.ERET_I = 1'b0;
        rd("sr_eret_wr", 5'd12, 32'h0000_0801);
        expect_out("int_im3_off", P_INT, 32'd0);
        bus.HWINT_I = 6'h02;
        expect_out("int_im3_on", P_INT, 32'd1);
        tick();
        rd("sr_handler", 5'd12, 32'h0000_0803);

        // Asynchronous reset between edges
        #2 RST_I = 1'b1;
        expect_out("async_sr", P_DAT, 32'd0);
        expect_out("async_epc", P_EPC, 32'd0);
        expect_out("async_int", P_INT, 32'd0);
        bus.HWINT_I = 6'h00;
        tick();
        RST_I = 1'b0;

        // Read-only / unimplemented registers ignore writes
        mtc0(5'd15, 32'h0000_0000);
        rd("prid_ro", 5'd15, C_PRID);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'd0);
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd("sel7_ro", 5'd7, 32'd0);
        rd("epc_untouched", 5'd14, 32'd0);
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd("sr_bits", 5'd12, 32'h0000_FC03);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
